// File: rtl/commit_retire.sv
// commit_retire: in-order retirement of scoreboard head entries.
// Drives regfile writes, store commit, CSR sequencing, exceptions, flushes.
//
// Ports:
//   clk_i, rst_i (sync, active-high), halt_i (blocks new commits in IDLE)
//   commit_valid_i/rd_i/rd_fpr_i/fu_i/ex_valid_i/result_i : per-port head
//   commit_ex_cause_i/commit_ex_tval_i : exception info of head (port 0)
//   commit_ack_o, waddr_o, wdata_o, we_gpr_o, we_fpr_o   : per-port retire
//   commit_lsu_o/commit_lsu_ready_i : store commit handshake
//   csr_valid_o, csr_done_i, csr_rdata_i : CSR sequencing
//   exception_*_o, flush_o : registered, one cycle after the event
//   instret_o : retired count; needs COMMIT_RETIRE_INSTRET_EN, else 0
module commit_retire #(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int XLEN = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         halt_i,
  input  logic [NR_COMMIT_PORTS-1:0]   commit_valid_i,
  input  logic [NR_COMMIT_PORTS*5-1:0] commit_rd_i,
  input  logic [NR_COMMIT_PORTS-1:0]   commit_rd_fpr_i,
  input  logic [NR_COMMIT_PORTS*4-1:0] commit_fu_i,
  input  logic [NR_COMMIT_PORTS-1:0]   commit_ex_valid_i,
  input  logic [NR_COMMIT_PORTS*XLEN-1:0] commit_result_i,
  input  logic [XLEN-1:0]              commit_ex_cause_i,
  input  logic [XLEN-1:0]              commit_ex_tval_i,
  output logic [NR_COMMIT_PORTS-1:0]   commit_ack_o,
  output logic [NR_COMMIT_PORTS*5-1:0] waddr_o,
  output logic [NR_COMMIT_PORTS*XLEN-1:0] wdata_o,
  output logic [NR_COMMIT_PORTS-1:0]   we_gpr_o,
  output logic [NR_COMMIT_PORTS-1:0]   we_fpr_o,
  output logic                         commit_lsu_o,
  input  logic                         commit_lsu_ready_i,
  output logic                         csr_valid_o,
  input  logic                         csr_done_i,
  input  logic [XLEN-1:0]              csr_rdata_i,
  output logic                         exception_valid_o,
  output logic [XLEN-1:0]              exception_cause_o,
  output logic [XLEN-1:0]              exception_tval_o,
  output logic                         flush_o,
  output logic [63:0]                  instret_o
);

  localparam logic [3:0] FU_STORE = 4'd2;
  localparam logic [3:0] FU_CSR   = 4'd6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CSR_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [4:0]      rd0;
  logic [3:0]      fu0;
  logic            fpr0;
  logic            go0, ex0, csr0, st0;
  logic            ack0, ack1, alu0, ex_take;
  logic            we_gpr0, we_fpr0;
  logic [XLEN-1:0] wdata0;

  logic            flush_q, exc_valid_q;
  logic [XLEN-1:0] exc_cause_q, exc_tval_q;

  assign rd0  = commit_rd_i[4:0];
  assign fu0  = commit_fu_i[3:0];
  assign fpr0 = commit_rd_fpr_i[0];
  assign go0  = !halt_i && commit_valid_i[0];
  assign ex0  = commit_ex_valid_i[0];
  assign csr0 = !ex0 && (fu0 == FU_CSR);
  assign st0  = !ex0 && (fu0 == FU_STORE);

  always_comb begin
    state_d      = state_q;
    ack0         = 1'b0;
    alu0         = 1'b0;
    ex_take      = 1'b0;
    we_gpr0      = 1'b0;
    we_fpr0      = 1'b0;
    commit_lsu_o = 1'b0;
    csr_valid_o  = 1'b0;
    wdata0       = commit_result_i[XLEN-1:0];
    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          if (go0) begin
            unique case (1'b1)
              ex0: begin
                ack0    = 1'b1;
                ex_take = 1'b1;
                state_d = FLUSH;
              end
              csr0: begin
                csr_valid_o = 1'b1;
                state_d     = CSR_WAIT;
              end
              st0: begin
                ack0         = commit_lsu_ready_i;
                commit_lsu_o = commit_lsu_ready_i;
              end
              default: begin
                ack0    = 1'b1;
                alu0    = 1'b1;
                we_gpr0 = !fpr0 && (rd0 != 5'd0);
                we_fpr0 = fpr0;
              end
            endcase
          end
        end
        CSR_WAIT: begin
          if (csr_done_i) begin
            ack0    = 1'b1;
            wdata0  = csr_rdata_i;
            we_gpr0 = (rd0 != 5'd0);
            state_d = FLUSH;
          end
        end
        FLUSH: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign commit_ack_o[0]  = ack0;
  assign we_gpr_o[0]      = we_gpr0;
  assign we_fpr_o[0]      = we_fpr0;
  assign waddr_o[4:0]     = rd0;
  assign wdata_o[XLEN-1:0] = wdata0;

  generate
    if (NR_COMMIT_PORTS > 1) begin : g_p1
      logic [4:0] rd1;
      logic [3:0] fu1;
      logic       fpr1, clash, ok1;
      assign rd1   = commit_rd_i[9:5];
      assign fu1   = commit_fu_i[7:4];
      assign fpr1  = commit_rd_fpr_i[1];
      // Same-file same-rd pairs are split so the later write wins.
      assign clash = (fpr1 == fpr0) && (rd1 == rd0);
      assign ok1   = alu0 && commit_valid_i[1] &&
                     !commit_ex_valid_i[1] &&
                     (fu1 != FU_CSR) && (fu1 != FU_STORE) &&
                     !clash;
      assign ack1            = ok1;
      assign commit_ack_o[1] = ok1;
      assign we_gpr_o[1]     = ok1 && !fpr1 && (rd1 != 5'd0);
      assign we_fpr_o[1]     = ok1 && fpr1;
      assign waddr_o[9:5]    = rd1;
      assign wdata_o[2*XLEN-1:XLEN] =
        commit_result_i[2*XLEN-1:XLEN];
    end else begin : g_no_p1
      assign ack1 = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flush_q     <= 1'b0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= '0;
      exc_tval_q  <= '0;
    end else begin
      flush_q     <= (state_d == FLUSH);
      exc_valid_q <= ex_take;
      if (ex_take) begin
        exc_cause_q <= commit_ex_cause_i;
        exc_tval_q  <= commit_ex_tval_i;
      end
    end
  end

  assign flush_o           = flush_q;
  assign exception_valid_o = exc_valid_q;
  assign exception_cause_o = exc_cause_q;
  assign exception_tval_o  = exc_tval_q;

`ifdef COMMIT_RETIRE_INSTRET_EN
  logic [63:0] instret_q;
  logic        cnt0;
  // A trapping head is acked but did not retire.
  assign cnt0 = ack0 && !ex_take;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_q + 64'(cnt0) + 64'(ack1);
    end
  end
  assign instret_o = instret_q;
`else
  assign instret_o = '0;
`endif

endmodule
